// File: rtl/sdio_dat_pkg.sv
// Shared types and constants for the SDIO DAT receive path.
package sdio_dat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_DATA,
    ST_CRC,
    ST_END
  } rx_state_t;

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_START = 2'b01;
  localparam logic [1:0] PH_DATA  = 2'b10;
  localparam logic [1:0] PH_CRC   = 2'b11;

  localparam int unsigned MAX_BLK_LEN = 2048;

  // Phase code presented to the line shifters while in a given state.
  function automatic logic [1:0] state_phase(input rx_state_t s);
    case (s)
      ST_DATA: return PH_DATA;
      ST_CRC:  return PH_CRC;
      default: return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sdio_dat_rx_pack.sv
// Byte assembler for received DAT samples: shift register, write strobe and
// sticky FIFO overflow flag.
module sdio_dat_rx_pack
  import sdio_dat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  rx_state_t  state,
  input  logic       abort,
  input  logic       width4,
  input  logic       ovf_clr,
  input  logic [3:0] dat_in,
  input  logic       fifo_full,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       overflow
);

  logic       sample_c;
  logic       byte_done_c;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic [7:0] sr_nxt_c;

  assign sample_c    = (state == ST_DATA) && !abort;
  assign byte_done_c = width4 ? cnt[0] : (cnt == 3'd7);
  assign sr_nxt_c    = width4 ? {sr[3:0], dat_in} : {sr[6:0], dat_in[0]};

  // Partial bytes are discarded whenever sampling stops (abort or leaving DATA).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sr       <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (ovf_clr) overflow <= 1'b0;
      if (!sample_c) begin
        cnt <= '0;
      end else begin
        sr  <= sr_nxt_c;
        cnt <= byte_done_c ? 3'd0 : cnt + 3'd1;
        if (byte_done_c) begin
          if (fifo_full) begin
            overflow <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= sr_nxt_c;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sdio_dat_rx_ctrl.sv
// SDIO client DAT receive sequencer (host-to-card block data).
// Optional start-bit timeout in WAIT_START: define NAC_TIMEOUT_EN.
module sdio_dat_rx_ctrl
  import sdio_dat_pkg::*;
#(
  parameter int unsigned BLK_LEN_W = 12,
  parameter int unsigned NAC_MAX   = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_start,
  input  logic                 rx_abort,
  input  logic                 bus_width_4,
  input  logic [BLK_LEN_W-1:0] blk_len,
  input  logic [3:0]           dat_in,
  input  logic [3:0]           line_crc_err,
  input  logic                 fifo_full,
  output logic [1:0]           dat_phase,
  output logic                 crc_rst,
  output logic                 crc_check_en,
  output logic [7:0]           wr_data,
  output logic                 wr_en,
  output logic                 blk_done,
  output logic                 crc_ok,
  output logic                 end_err,
  output logic                 overflow,
  output logic                 busy
);

  localparam int unsigned CNT_W = BLK_LEN_W + 3;

  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 width4_q, width4_nxt;
  logic [BLK_LEN_W-1:0] blk_len_q, blk_len_nxt;
  logic [1:0]           dat_phase_nxt;
  logic                 crc_rst_nxt, crc_check_en_nxt, blk_done_nxt;
  logic                 crc_ok_nxt, end_err_nxt, busy_nxt;
  logic                 len_ok_c, start_bit_c, timeout_c;
  logic [3:0]           active_mask_c;
  logic [CNT_W-1:0]     data_load_c;

  assign len_ok_c      = (blk_len != '0) && (32'(blk_len) <= MAX_BLK_LEN);
  assign start_bit_c   = width4_q ? (dat_in == 4'h0) : !dat_in[0];
  assign active_mask_c = width4_q ? 4'hF : 4'h1;
  assign data_load_c   = width4_q ? ({2'b00, blk_len_q, 1'b0} - CNT_W'(1))
                                  : ({blk_len_q, 3'b000} - CNT_W'(1));

`ifdef NAC_TIMEOUT_EN
  localparam int unsigned NAC_W = $clog2(NAC_MAX + 1);
  logic [NAC_W-1:0] nac_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         nac_cnt <= '0;
    else if (state == ST_WAIT_START) nac_cnt <= nac_cnt + NAC_W'(1);
    else                             nac_cnt <= '0;
  end

  assign timeout_c = (state == ST_WAIT_START) && (nac_cnt == NAC_W'(NAC_MAX - 1));
`else
  // No timeout hardware; NAC_MAX only matters when the timeout is built.
  assign timeout_c = 1'b0 & (NAC_MAX == 0);
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      width4_q     <= 1'b0;
      blk_len_q    <= '0;
      dat_phase    <= PH_IDLE;
      crc_rst      <= 1'b0;
      crc_check_en <= 1'b0;
      blk_done     <= 1'b0;
      crc_ok       <= 1'b0;
      end_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      width4_q     <= width4_nxt;
      blk_len_q    <= blk_len_nxt;
      dat_phase    <= dat_phase_nxt;
      crc_rst      <= crc_rst_nxt;
      crc_check_en <= crc_check_en_nxt;
      blk_done     <= blk_done_nxt;
      crc_ok       <= crc_ok_nxt;
      end_err      <= end_err_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered from state_nxt.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    width4_nxt   = width4_q;
    blk_len_nxt  = blk_len_q;
    crc_rst_nxt  = 1'b0;
    blk_done_nxt = 1'b0;
    crc_ok_nxt   = 1'b0;
    end_err_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rx_start && len_ok_c) begin
          state_nxt   = ST_WAIT_START;
          width4_nxt  = bus_width_4;
          blk_len_nxt = blk_len;
          crc_rst_nxt = 1'b1;
        end
      end
      ST_WAIT_START: begin
        if (start_bit_c) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = data_load_c;
        end else if (timeout_c) begin
          state_nxt    = ST_IDLE;
          blk_done_nxt = 1'b1;
          end_err_nxt  = 1'b1;
        end
      end
      ST_DATA: begin
        bit_cnt_nxt = bit_cnt - CNT_W'(1);
        if (bit_cnt == '0) begin
          state_nxt   = ST_CRC;
          bit_cnt_nxt = CNT_W'(15);
        end
      end
      ST_CRC: begin
        bit_cnt_nxt = bit_cnt - CNT_W'(1);
        if (bit_cnt == '0) state_nxt = ST_END;
      end
      ST_END: begin
        state_nxt    = ST_IDLE;
        blk_done_nxt = 1'b1;
        end_err_nxt  = |(~dat_in & active_mask_c);
        crc_ok_nxt   = ~|(line_crc_err & active_mask_c);
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (rx_abort) begin
      state_nxt    = ST_IDLE;
      crc_rst_nxt  = 1'b0;
      blk_done_nxt = 1'b0;
      crc_ok_nxt   = 1'b0;
      end_err_nxt  = 1'b0;
    end

    dat_phase_nxt    = state_phase(state_nxt);
    busy_nxt         = (state_nxt != ST_IDLE);
    crc_check_en_nxt = busy_nxt;
  end

  sdio_dat_rx_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .abort     (rx_abort),
    .width4    (width4_q),
    .ovf_clr   (crc_rst_nxt),
    .dat_in    (dat_in),
    .fifo_full (fifo_full),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_sdio_dat_rx_ctrl.sv
// Directed self-checking bench for sdio_dat_rx_ctrl (timeout cases under NAC_TIMEOUT_EN).
module tb_sdio_dat_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_start = 1'b0;
  logic        rx_abort = 1'b0;
  logic        bus_width_4 = 1'b0;
  logic [11:0] blk_len = '0;
  logic [3:0]  dat_in = 4'hF;
  logic [3:0]  line_crc_err = '0;
  logic        fifo_full = 1'b0;
  logic [1:0]  dat_phase;
  logic        crc_rst, crc_check_en, wr_en, blk_done, crc_ok, end_err, overflow, busy;
  logic [7:0]  wr_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdio_dat_rx_ctrl #(.BLK_LEN_W(12), .NAC_MAX(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_start     (rx_start),
    .rx_abort     (rx_abort),
    .bus_width_4  (bus_width_4),
    .blk_len      (blk_len),
    .dat_in       (dat_in),
    .line_crc_err (line_crc_err),
    .fifo_full    (fifo_full),
    .dat_phase    (dat_phase),
    .crc_rst      (crc_rst),
    .crc_check_en (crc_check_en),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .blk_done     (blk_done),
    .crc_ok       (crc_ok),
    .end_err      (end_err),
    .overflow     (overflow),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete block: start bit, bytes (MSB first), 16 CRC cycles, end bit.
  task automatic run_block(input string tag, input logic w4, input int len,
                           input logic [31:0] bytes, input logic [3:0] crc_err,
                           input logic [3:0] end_bits, input int full_idx,
                           input logic exp_ok, input logic exp_eerr, input logic exp_ovf);
    logic [7:0] b;
    int ph;
    bus_width_4 = w4;
    blk_len     = 12'(len);
    rx_start    = 1'b1;
    dat_in      = 4'hF;
    step();
    rx_start = 1'b0;
    chk({tag, " crc_rst"}, 32'(crc_rst), 1);
    chk({tag, " busy"}, 32'(busy), 1);
    step();
    chk({tag, " wait phase"}, 32'(dat_phase), 0);
    chk({tag, " crc_check_en"}, 32'(crc_check_en), 1);
    dat_in = w4 ? 4'h0 : 4'hE;
    step();
    chk({tag, " data phase"}, 32'(dat_phase), 2);
    for (int k = 0; k < len; k++) begin
      b = bytes[31-8*k -: 8];
      fifo_full = (k == full_idx);
      for (int s = 0; s < (w4 ? 2 : 8); s++) begin
        dat_in = w4 ? ((s == 0) ? b[7:4] : b[3:0]) : {3'b111, b[7-s]};
        step();
        if (s == (w4 ? 1 : 7)) begin
          chk($sformatf("%s wr_en byte%0d", tag, k), 32'(wr_en), (k != full_idx) ? 1 : 0);
          if (k != full_idx) chk($sformatf("%s wr_data byte%0d", tag, k), 32'(wr_data), 32'(b));
        end else begin
          chk($sformatf("%s no wr_en byte%0d s%0d", tag, k, s), 32'(wr_en), 0);
        end
      end
    end
    fifo_full    = 1'b0;
    line_crc_err = crc_err;
    ph = 0;
    for (int i = 0; i < 16; i++) begin
      if (dat_phase == 2'b11) ph++;
      dat_in = 4'(i);
      step();
    end
    chk({tag, " crc cycles"}, 32'(ph), 16);
    chk({tag, " end phase"}, 32'(dat_phase), 0);
    dat_in = end_bits;
    step();
    chk({tag, " blk_done"}, 32'(blk_done), 1);
    chk({tag, " crc_ok"}, 32'(crc_ok), 32'(exp_ok));
    chk({tag, " end_err"}, 32'(end_err), 32'(exp_eerr));
    chk({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, " idle busy"}, 32'(busy), 0);
    chk({tag, " idle crc_check_en"}, 32'(crc_check_en), 0);
    line_crc_err = '0;
    dat_in = 4'hF;
    step();
    chk({tag, " blk_done pulse"}, 32'(blk_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("reset outputs", {20'b0, dat_phase, crc_rst, crc_check_en, wr_data, wr_en, blk_done,
                          crc_ok, end_err, overflow, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post-reset busy", 32'(busy), 0);

    run_block("b1", 1'b0, 2, 32'hA53C_0000, 4'h0, 4'hF, -1, 1'b1, 1'b0, 1'b0);
    run_block("b4", 1'b1, 4, 32'h1234_5678, 4'h0, 4'hF, -1, 1'b1, 1'b0, 1'b0);
    run_block("crc4", 1'b1, 1, 32'hAB00_0000, 4'b0100, 4'hF, -1, 1'b0, 1'b0, 1'b0);
    run_block("crc1", 1'b0, 1, 32'hAB00_0000, 4'b0100, 4'hF, -1, 1'b1, 1'b0, 1'b0);
    run_block("crc1l0", 1'b0, 1, 32'h6600_0000, 4'b0001, 4'hF, -1, 1'b0, 1'b0, 1'b0);
    run_block("end1", 1'b0, 1, 32'h5A00_0000, 4'h0, 4'hE, -1, 1'b1, 1'b1, 1'b0);
    run_block("end1m", 1'b0, 1, 32'hC300_0000, 4'h0, 4'h1, -1, 1'b1, 1'b0, 1'b0);
    run_block("end4", 1'b1, 1, 32'hF000_0000, 4'h0, 4'b1011, -1, 1'b1, 1'b1, 1'b0);
    run_block("ovf", 1'b0, 2, 32'h1122_0000, 4'h0, 4'hF, 1, 1'b1, 1'b0, 1'b1);
    step();
    chk("overflow sticky", 32'(overflow), 1);

    // New block clears overflow; partial 4-bit start ignored; abort mid-DATA.
    bus_width_4 = 1'b1; blk_len = 12'd2; rx_start = 1'b1; dat_in = 4'hF;
    step();
    rx_start = 1'b0;
    chk("overflow cleared", 32'(overflow), 0);
    dat_in = 4'b1110;
    repeat (3) step();
    chk("partial start busy", 32'(busy), 1);
    chk("partial start phase", 32'(dat_phase), 0);
    dat_in = 4'h0;
    step();
    chk("abort pre data", 32'(dat_phase), 2);
    dat_in = 4'h1;
    step();
    rx_abort = 1'b1; dat_in = 4'h2;
    step();
    rx_abort = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort wr_en", 32'(wr_en), 0);
    chk("abort phase", 32'(dat_phase), 0);
    dat_in = 4'hF;
    step();
    chk("abort no blk_done", 32'(blk_done), 0);
    run_block("part", 1'b1, 1, 32'h9C00_0000, 4'h0, 4'hF, -1, 1'b1, 1'b0, 1'b0);

    // Rejected starts.
    blk_len = 12'd0; rx_start = 1'b1;
    step();
    chk("len0 ignored", 32'(busy), 0);
    blk_len = 12'd2049;
    step();
    chk("len2049 ignored", 32'(busy), 0);
    blk_len = 12'd2048; rx_abort = 1'b1;
    step();
    chk("abort beats start", 32'(busy), 0);
    rx_abort = 1'b0;
    step();
    rx_start = 1'b0;
    chk("len2048 accepted", 32'(busy), 1);

`ifdef NAC_TIMEOUT_EN
    repeat (7) step();
    chk("nac waiting", {busy, blk_done}, 32'b10);
    step();
    chk("nac blk_done", 32'(blk_done), 1);
    chk("nac crc_ok", 32'(crc_ok), 0);
    chk("nac end_err", 32'(end_err), 1);
    chk("nac idle", 32'(busy), 0);
`else
    repeat (40) step();
    chk("wait forever busy", 32'(busy), 1);
    chk("wait forever no done", 32'(blk_done), 0);
    blk_len = 12'd3; rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    chk("start while busy", 32'(crc_rst), 0);
    rx_abort = 1'b1;
    step();
    rx_abort = 1'b0;
    chk("wait abort", 32'(busy), 0);
`endif

    // Asynchronous reset in the middle of the CRC phase.
    bus_width_4 = 1'b0; blk_len = 12'd1; rx_start = 1'b1; dat_in = 4'hF;
    step();
    rx_start = 1'b0;
    dat_in = 4'hE;
    step();
    for (int i = 0; i < 8; i++) begin
      dat_in = {3'b111, 1'(i & 1)};
      step();
    end
    repeat (3) step();
    chk("pre-reset crc phase", 32'(dat_phase), 3);
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", {20'b0, dat_phase, crc_rst, crc_check_en, wr_data, wr_en, blk_done,
                                crc_ok, end_err, overflow, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("after reset idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
